// File: rtl/ccr_flag_reg_if.sv
// rtl/ccr_flag_reg_if.sv - CCR stage bundle: decode enables, EX flags, jump/interrupt controls, CCR outputs
interface ccr_flag_reg_if;
  logic       z_en_d;
  logic       n_en_d;
  logic       c_en_d;
  logic       v_en_d;
  logic       stall;
  logic       flush;
  logic       alu_z;
  logic       alu_n;
  logic       alu_c;
  logic       alu_v;
  logic       jz_taken;
  logic       jn_taken;
  logic       jc_taken;
  logic       int_save;
  logic       rti_restore;
  logic [3:0] ccr;
  logic [3:0] ccr_fwd;
  logic       shadow_valid;
  logic       save_ovf;

  modport master (
    output z_en_d, n_en_d, c_en_d, v_en_d,
    output stall, flush,
    output alu_z, alu_n, alu_c, alu_v,
    output jz_taken, jn_taken, jc_taken,
    output int_save, rti_restore,
    input  ccr, ccr_fwd, shadow_valid, save_ovf
  );

  modport slave (
    input  z_en_d, n_en_d, c_en_d, v_en_d,
    input  stall, flush,
    input  alu_z, alu_n, alu_c, alu_v,
    input  jz_taken, jn_taken, jc_taken,
    input  int_save, rti_restore,
    output ccr, ccr_fwd, shadow_valid, save_ovf
  );
endinterface

// File: rtl/ccr_flag_reg.sv
// rtl/ccr_flag_reg.sv - condition-code register: staged flag enables, EX commit, jump clears, interrupt shadow
module ccr_flag_reg (
  input  logic           clk,
  input  logic           rst_n,
  ccr_flag_reg_if.slave  bus
);

  typedef enum logic {
    SH_EMPTY = 1'b0,
    SH_FULL  = 1'b1
  } sh_state_t;

  sh_state_t  sh_state;
  logic [3:0] en_q;
  logic [3:0] ccr_q;
  logic [3:0] shadow_q;
  logic       save_ovf_q;

  logic [3:0] alu_flags;
  logic [3:0] jump_clr;
  logic [3:0] wr_mask;
  logic       restore;
  logic [3:0] ccr_next;

  assign alu_flags = {bus.alu_v, bus.alu_c, bus.alu_n, bus.alu_z};
  assign jump_clr  = {1'b0, bus.jc_taken, bus.jn_taken, bus.jz_taken};
  assign restore   = bus.rti_restore && (sh_state == SH_FULL);

  // ALU write beats jump clear per bit; a valid restore overrides both.
  always_comb begin
    wr_mask  = bus.stall ? 4'b0000 : en_q;
    ccr_next = (alu_flags & wr_mask) | (ccr_q & ~wr_mask & ~jump_clr);
    if (restore) begin
      ccr_next = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 4'b0000;
    end else if (bus.flush) begin
      en_q <= 4'b0000;
    end else if (!bus.stall) begin
      en_q <= {bus.v_en_d, bus.c_en_d, bus.n_en_d, bus.z_en_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q <= 4'b0000;
    end else begin
      ccr_q <= ccr_next;
    end
  end

  // Save captures ccr_next so a simultaneous EX commit or restore is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_state   <= SH_EMPTY;
      shadow_q   <= 4'b0000;
      save_ovf_q <= 1'b0;
    end else begin
      case (sh_state)
        SH_EMPTY: begin
          if (bus.int_save) begin
            shadow_q <= ccr_next;
            sh_state <= SH_FULL;
          end
        end
        SH_FULL: begin
          if (bus.int_save) begin
            shadow_q   <= ccr_next;
            save_ovf_q <= 1'b1;
            sh_state   <= SH_FULL;
          end else if (bus.rti_restore) begin
            sh_state <= SH_EMPTY;
          end
        end
        default: sh_state <= SH_EMPTY;
      endcase
    end
  end

  assign bus.ccr          = ccr_q;
  assign bus.ccr_fwd      = ccr_next;
  assign bus.shadow_valid = (sh_state == SH_FULL);
  assign bus.save_ovf     = save_ovf_q;

endmodule

// File: tb/tb_ccr_flag_reg.sv
// tb/tb_ccr_flag_reg.sv - directed vector bench for ccr_flag_reg
module tb_ccr_flag_reg;

  logic clk;
  logic rst_n;
  ccr_flag_reg_if bus ();

  ccr_flag_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;     // {v,c,n,z}
    logic       stall;
    logic       flush;
    logic [3:0] alu;    // {v,c,n,z}
    logic [2:0] jmp;    // {jc,jn,jz}
    logic       save;
    logic       rti;
    logic [3:0] e_ccr;
    logic [3:0] e_fwd;
    logic       e_sv;
    logic       e_ovf;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(logic [3:0] en, logic stall, logic flush, logic [3:0] alu,
                              logic [2:0] jmp, logic save, logic rti,
                              logic [3:0] e_ccr, logic [3:0] e_fwd, logic e_sv, logic e_ovf);
    vec_t v;
    v.en = en; v.stall = stall; v.flush = flush; v.alu = alu; v.jmp = jmp;
    v.save = save; v.rti = rti;
    v.e_ccr = e_ccr; v.e_fwd = e_fwd; v.e_sv = e_sv; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    {bus.v_en_d, bus.c_en_d, bus.n_en_d, bus.z_en_d} = v.en;
    bus.stall = v.stall;
    bus.flush = v.flush;
    {bus.alu_v, bus.alu_c, bus.alu_n, bus.alu_z} = v.alu;
    {bus.jc_taken, bus.jn_taken, bus.jz_taken} = v.jmp;
    bus.int_save    = v.save;
    bus.rti_restore = v.rti;
  endtask

  task automatic check_outs(string tag, logic [3:0] e_ccr, logic [3:0] e_fwd, logic e_sv, logic e_ovf);
    chk({tag, " ccr"}, bus.ccr, e_ccr);
    chk({tag, " ccr_fwd"}, bus.ccr_fwd, e_fwd);
    chk({tag, " shadow_valid"}, {3'b000, bus.shadow_valid}, {3'b000, e_sv});
    chk({tag, " save_ovf"}, {3'b000, bus.save_ovf}, {3'b000, e_ovf});
  endtask

  initial begin
    vec_t idle;
    n_cmp = 0;
    n_bad = 0;
    idle = mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0000, 4'b0000, 0, 0);

    //     en       st fl alu      jmp     sv rti   ccr      fwd      sv ovf
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0000, 4'b0000, 0, 0)); // 0
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b1010, 3'b000, 0, 0, 4'b0000, 4'b1010, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b1010, 4'b1010, 0, 0));
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b1010, 4'b1010, 0, 0));
    vq.push_back(mk(4'b0100, 0, 0, 4'b1111, 3'b000, 0, 0, 4'b1010, 4'b1111, 0, 0)); // 5
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b101, 0, 0, 4'b1111, 4'b1010, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b1010, 4'b1010, 0, 0));
    vq.push_back(mk(4'b0010, 0, 0, 4'b0000, 3'b010, 0, 0, 4'b1010, 4'b1000, 0, 0));
    vq.push_back(mk(4'b0000, 1, 0, 4'b0010, 3'b000, 0, 0, 4'b1000, 4'b1000, 0, 0));
    vq.push_back(mk(4'b0000, 1, 0, 4'b0000, 3'b000, 0, 0, 4'b1000, 4'b1000, 0, 0)); // 10
    vq.push_back(mk(4'b0000, 1, 0, 4'b0010, 3'b000, 0, 0, 4'b1000, 4'b1000, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0010, 3'b000, 0, 0, 4'b1000, 4'b1010, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b1010, 4'b1010, 0, 0));
    vq.push_back(mk(4'b0010, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b1010, 4'b1010, 0, 0));
    vq.push_back(mk(4'b0000, 1, 1, 4'b0000, 3'b000, 0, 0, 4'b1010, 4'b1010, 0, 0)); // 15
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b1010, 4'b1010, 0, 0));
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b1010, 4'b1010, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0101, 3'b000, 0, 0, 4'b1010, 4'b0101, 0, 0));
    vq.push_back(mk(4'b0001, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0101, 4'b0101, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 1, 0, 4'b0101, 4'b0100, 0, 0)); // 20
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0100, 4'b0100, 1, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b1011, 3'b000, 0, 0, 4'b0100, 4'b1011, 1, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 1, 4'b1011, 4'b0100, 1, 0));
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 1, 0, 4'b0100, 4'b0100, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0110, 3'b000, 1, 0, 4'b0100, 4'b0110, 1, 0)); // 25
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0110, 4'b0110, 1, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b1001, 3'b000, 0, 0, 4'b0110, 4'b1001, 1, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 1, 4'b1001, 4'b0110, 1, 1));
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0110, 4'b0110, 0, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b1100, 3'b001, 0, 1, 4'b0110, 4'b1100, 0, 1)); // 30
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b1100, 4'b1100, 0, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0011, 3'b000, 1, 0, 4'b1100, 4'b0011, 0, 1));
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0011, 4'b0011, 1, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b1111, 3'b000, 0, 0, 4'b0011, 4'b1111, 1, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b1000, 3'b000, 1, 1, 4'b1111, 4'b0011, 1, 1)); // 35
    vq.push_back(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0011, 4'b0011, 1, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b1100, 3'b000, 0, 0, 4'b0011, 4'b1100, 1, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 1, 4'b1100, 4'b0011, 1, 1));
    vq.push_back(mk(4'b0000, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0011, 4'b0011, 0, 1));

    rst_n = 1'b0;
    drive(idle);
    #12;
    check_outs("in_reset", 4'b0000, 4'b0000, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #1;
      check_outs($sformatf("vec%0d", i), vq[i].e_ccr, vq[i].e_fwd, vq[i].e_sv, vq[i].e_ovf);
      @(negedge clk);
    end

    // Mid-cycle async reset discards staged enables, shadow state and sticky overflow.
    drive(mk(4'b1111, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    @(posedge clk);
    #3;
    drive(mk(4'b0000, 0, 0, 4'b1111, 3'b000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 4'b0000, 4'b0000, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_outs("rst_hold", 4'b0000, 4'b0000, 0, 0);
    rst_n = 1'b1;

    // First edge after release stages z_en; flag appears one cycle later.
    drive(mk(4'b0001, 0, 0, 4'b0000, 3'b000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    @(negedge clk);
    drive(mk(4'b0000, 0, 0, 4'b0001, 3'b000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    #1;
    check_outs("post_rst_t1", 4'b0000, 4'b0001, 0, 0);
    @(negedge clk);
    drive(idle);
    #1;
    check_outs("post_rst_t2", 4'b0001, 4'b0001, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccr_flag_reg.md
# ccr_flag_reg

Condition-code register stage that sits directly downstream of the flag-enable decoder. It registers the decode-stage Z/N/C/V write enables into an ID/EX holding register, aligns them with the execute-stage ALU flag results, and commits the selected bits into the 4-bit CCR. It also clears flags after taken conditional jumps, saves the CCR to a shadow register on interrupt entry, and restores it on RTI. Its outputs feed the branch unit and the CCR push path.

## Interface
- No parameters. Widths are fixed: CCR is 4 bits, {V,C,N,Z} = ccr[3:0].
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- z_en_d, n_en_d, c_en_d, v_en_d  in  1 each  decode-stage flag write enables.
- stall  in  1  holds the staged enables and suppresses the EX commit.
- flush  in  1  bubbles the staged enables to 0 at the next edge.
- alu_z, alu_n, alu_c, alu_v  in  1 each  execute-stage flag values.
- jz_taken, jn_taken, jc_taken  in  1 each  taken conditional jump; clears that flag.
- int_save  in  1  pulse; interrupt accepted, so copy the CCR to the shadow.
- rti_restore  in  1  pulse; restore the CCR from the shadow.
- ccr  out  4  architectural CCR.
- ccr_fwd  out  4  combinational next CCR value, used for same-cycle branch resolution.
- shadow_valid  out  1  the shadow holds a saved CCR.
- save_ovf  out  1  sticky flag: int_save arrived while shadow_valid was already 1.

## Operation
- Stage register en_q[3:0], captured at each rising edge:
  - flush=1 → en_q = 0. flush has priority over stall.
  - else stall=1 → en_q holds.
  - else en_q = {v_en_d, c_en_d, n_en_d, z_en_d}.
- Per-bit next-CCR priority, highest first:
  1. rti_restore=1 and shadow_valid=1 → all bits take the shadow value.
  2. stall=0 and en_q[i]=1 → bit i takes its alu flag.
  3. jump clear: jz_taken clears Z, jn_taken clears N, jc_taken clears C.
  4. otherwise the bit holds.
- A jump clear and an ALU write to the same bit in the same cycle → the ALU write wins.
- rti_restore with shadow_valid=0 → ignored; rules 2–4 apply normally.
- ccr_fwd equals the next-CCR value; ccr <= ccr_fwd at every edge.
- Shadow save (int_save=1):
  - shadow <= ccr_fwd, so the in-flight EX update is included.
  - shadow_valid <= 1.
  - if shadow_valid was already 1: the shadow is overwritten and save_ovf <= 1.
- Shadow restore (rti_restore=1 with shadow_valid=1): shadow_valid <= 0.
- int_save and rti_restore in the same cycle → the restore applies to the CCR; the shadow then captures the restored value and shadow_valid stays 1.
- save_ovf is cleared only by reset.
- Shadow state machine:
  - EMPTY --int_save--> FULL
  - FULL --rti_restore--> EMPTY
  - FULL --int_save--> FULL, and save_ovf is set.

## Timing
- Reset (rst_n=0, asynchronous): ccr=0, en_q=0, shadow=0, shadow_valid=0, save_ovf=0. ccr_fwd then reflects the inputs combinationally.
- Reset asserted mid-operation discards the staged enables and the shadow immediately. The first edge after release behaves as if the cycle following reset were the first.
- Enable latency:
  - enables presented in cycle t are captured at edge t;
  - the ALU flags are sampled in cycle t+1 and appear on ccr_fwd in t+1;
  - ccr updates at edge t+1 and is visible from cycle t+2.
- Stall: while stall=1, the staged instruction does not commit. It commits in the first cycle with stall=0, using the ALU flags present in that cycle.
- Jump clear, restore and save each take effect on ccr or shadow at the edge of the cycle in which they are asserted.

## Test plan
- Reset, then enables 4'b1111 with alu {v,c,n,z}=1010 one cycle later → ccr_fwd=4'b1010 in t+1; ccr=4'b1010 in t+2; all other outputs 0.
- ccr=4'b1111; only c_en staged, alu_c=0, jc_taken=1 and jz_taken=1 in the same cycle → ccr=4'b1010. The ALU wrote C to 0; Z was cleared by the jump.
- Staged n_en with stall held high for 3 cycles, alu_n toggling → ccr unchanged during the stall. alu_n=1 in the release cycle → N=1. A flush in the stalled cycle instead → no commit.
- ccr=4'b0101 with staged z_en and alu_z=0, plus int_save → shadow=4'b0100 and shadow_valid=1. Later rti_restore with ccr=4'b1011 → ccr=4'b0100 and shadow_valid=0.
- Second int_save while FULL → save_ovf=1, held sticky. rti_restore while EMPTY → ccr follows the normal ALU/jump rules.
- int_save and rti_restore together with shadow=4'b0011 → ccr=4'b0011, shadow=4'b0011, shadow_valid=1. Assert rst_n=0 mid-cycle → all outputs 0 immediately.
